// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the CORDIC iteration controller: FSM state encoding,
// ROM address width and the default first/last iteration addresses.
package cordic_ctrl_pkg;

    localparam int ADRS_W         = 5;
    localparam int ADRS_FIRST_DEF = 1;
    localparam int ADRS_LAST_DEF  = 31;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ITER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/cordic_iter_ctrl.sv
// Sequences one CORDIC run: load strobe, ROM address sweep ADRS_FIRST..ADRS_LAST, iteration strobes.
// Latency: LD_INIT 1 cycle after start, DONE N+3 cycles after start, held until ACK_FSM.
// Backpressure: with CORDIC_STALL_EN defined, STALL freezes the sweep and masks EN_ROM1/EN_ITER.
module cordic_iter_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int ADRS_FIRST = ADRS_FIRST_DEF,
    parameter int ADRS_LAST  = ADRS_LAST_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BEG_FSM,
    input  logic              ACK_FSM,
`ifdef CORDIC_STALL_EN
    input  logic              STALL,
`endif
    output logic              EN_ROM1,
    output logic [ADRS_W-1:0] ADRS,
    output logic              LD_INIT,
    output logic              EN_ITER,
    output logic              READY,
    output logic              DONE
);

    localparam logic [ADRS_W-1:0] A_FIRST = ADRS_W'(ADRS_FIRST);
    localparam logic [ADRS_W-1:0] A_LAST  = ADRS_W'(ADRS_LAST);

    ctrl_state_e       state;
    ctrl_state_e       state_nxt;
    logic [ADRS_W-1:0] adrs_q;
    logic              pend_q;
    logic              stall_in;
    logic              hold;

`ifdef CORDIC_STALL_EN
    assign stall_in = STALL;
`else
    assign stall_in = 1'b0;
`endif

    // Stall only matters while the ROM/datapath pipeline is active.
    assign hold = stall_in && ((state == ST_ITER) || (state == ST_DRAIN));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (BEG_FSM) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_ITER;
            ST_ITER:  if (!hold && (adrs_q == A_LAST)) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!hold) state_nxt = ST_DONE;
            ST_DONE:  if (ACK_FSM) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            adrs_q <= '0;
            pend_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Pending marks a ROM read in flight; its data is consumed next unstalled cycle.
            if (!hold) begin
                pend_q <= (state == ST_ITER);
            end
            if (state == ST_LOAD) begin
                adrs_q <= A_FIRST;
            end else if ((state == ST_ITER) && !hold && (adrs_q != A_LAST)) begin
                adrs_q <= adrs_q + 1'b1;
            end
        end
    end

    assign EN_ROM1 = (state == ST_ITER) && !hold;
    assign EN_ITER = pend_q && !hold;
    assign ADRS    = adrs_q;
    assign LD_INIT = (state == ST_LOAD);
    assign READY   = (state == ST_IDLE);
    assign DONE    = (state == ST_DONE);

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Scoreboard bench for cordic_iter_ctrl: a run-level timing model predicts every strobe.
// Stall scenarios are exercised when CORDIC_STALL_EN is defined.
module tb_cordic_iter_ctrl;
    import cordic_ctrl_pkg::*;

    localparam int FIRST = 1;
    localparam int LAST  = 31;
    localparam int N     = LAST - FIRST + 1;
    localparam int MAXC  = 32768;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST, BEG_FSM, ACK_FSM;
    logic EN_ROM1, LD_INIT, EN_ITER, READY, DONE;
    logic [ADRS_W-1:0] ADRS;
`ifdef CORDIC_STALL_EN
    logic STALL;
`endif

    logic rst1, beg1, ack1;
    logic en_rom_b, ld_b, it_b, rdy_b, done_b;
    logic [ADRS_W-1:0] adrs_b;

    cordic_iter_ctrl dut (
        .CLK(CLK), .RST(RST), .BEG_FSM(BEG_FSM), .ACK_FSM(ACK_FSM),
`ifdef CORDIC_STALL_EN
        .STALL(STALL),
`endif
        .EN_ROM1(EN_ROM1), .ADRS(ADRS), .LD_INIT(LD_INIT), .EN_ITER(EN_ITER),
        .READY(READY), .DONE(DONE)
    );

    cordic_iter_ctrl #(.ADRS_FIRST(4), .ADRS_LAST(4)) dut1 (
        .CLK(CLK), .RST(rst1), .BEG_FSM(beg1), .ACK_FSM(ack1),
`ifdef CORDIC_STALL_EN
        .STALL(1'b0),
`endif
        .EN_ROM1(en_rom_b), .ADRS(adrs_b), .LD_INIT(ld_b), .EN_ITER(it_b),
        .READY(rdy_b), .DONE(done_b)
    );

    typedef struct packed { int cyc; int adrs; } ev_t;

    int  exp_ld[$];
    ev_t exp_rd[$];
    int  exp_it[$];
    int  exp_done[$];
    bit  plan [0:MAXC-1];
    int  rd_t [0:31];
    int  cyc, done_t, n_cmp, n_bad;
    bit  exp_ready, mon_en, m_idle, done_q;
    ev_t mon_e;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops an expectation for every strobe the DUT presents.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (LD_INIT) begin
                if (exp_ld.size() == 0) chk("ld_init_unexpected", int'(LD_INIT), 0);
                else chk("ld_init_cycle", cyc, exp_ld.pop_front());
            end
            if (EN_ROM1) begin
                if (exp_rd.size() == 0) chk("en_rom1_unexpected", int'(EN_ROM1), 0);
                else begin
                    mon_e = exp_rd.pop_front();
                    chk("en_rom1_cycle", cyc, mon_e.cyc);
                    chk("adrs_on_read", int'(ADRS), mon_e.adrs);
                end
            end
            if (EN_ITER) begin
                if (exp_it.size() == 0) chk("en_iter_unexpected", int'(EN_ITER), 0);
                else chk("en_iter_cycle", cyc, exp_it.pop_front());
            end
            if (DONE && !done_q) begin
                if (exp_done.size() == 0) chk("done_unexpected", int'(DONE), 0);
                else chk("done_rise_cycle", cyc, exp_done.pop_front());
            end
            if (DONE) chk("adrs_hold_in_done", int'(ADRS), LAST);
            chk("ready", int'(READY), int'(exp_ready));
            done_q = DONE;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
`ifdef CORDIC_STALL_EN
        STALL = plan[cyc];
`endif
        exp_ready = m_idle;
    endtask

    task automatic fill_plan(input int c, input bit rnd);
        for (int t = c + 1; t < c + 100; t++) begin
`ifdef CORDIC_STALL_EN
            plan[t] = rnd && ($urandom_range(0, 7) == 0);
`else
            plan[t] = 1'b0;
`endif
        end
    endtask

    // Run model: every cycle from c+2 advances one step unless stalled.
    task automatic start_run(input int c);
        int  t;
        ev_t e;
        exp_ld.push_back(c + 1);
        t = c + 2;
        for (int j = 0; j < N; j++) begin
            while (plan[t]) t++;
            rd_t[j] = t;
            e.cyc = t;
            e.adrs = FIRST + j;
            exp_rd.push_back(e);
            t++;
        end
        for (int j = 1; j < N; j++) exp_it.push_back(rd_t[j]);
        while (plan[t]) t++;
        exp_it.push_back(t);
        done_t = t + 1;
        exp_done.push_back(done_t);
        m_idle = 1'b0;
    endtask

    task automatic apply(input bit beg, input bit ack);
        BEG_FSM = beg;
        ACK_FSM = ack;
        if (m_idle) begin
            if (beg) start_run(cyc);
        end else if ((cyc >= done_t) && ack) begin
            m_idle = 1'b1;
        end
    endtask

    task automatic drive_run(input int ack_dly, input bit beg_hold, input bit beg_at_ack);
        while (cyc < done_t + ack_dly - 1) begin
            tick();
            apply(beg_hold, 1'b0);
        end
        tick();
        apply(beg_hold | beg_at_ack, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en_rom1"}, int'(EN_ROM1), 0);
        chk({tag, "_en_iter"}, int'(EN_ITER), 0);
        chk({tag, "_ld_init"}, int'(LD_INIT), 0);
        chk({tag, "_done"},    int'(DONE), 0);
        chk({tag, "_adrs"},    int'(ADRS), 0);
        chk({tag, "_ready"},   int'(READY), 1);
    endtask

    initial begin
        int c0, r, guard, runs;
        RST = 1'b1; BEG_FSM = 1'b0; ACK_FSM = 1'b0;
`ifdef CORDIC_STALL_EN
        STALL = 1'b0;
`endif
        rst1 = 1'b1; beg1 = 1'b0; ack1 = 1'b0;
        cyc = -1; m_idle = 1'b1; mon_en = 1'b0; exp_ready = 1'b1; done_q = 1'b0;
        n_cmp = 0; n_bad = 0; done_t = 0;

        repeat (3) tick();
        chk_reset_outputs("por");
        chk("por_dut1_ready", int'(rdy_b), 1);
        chk("por_dut1_adrs", int'(adrs_b), 0);
        RST = 1'b0; rst1 = 1'b0;
        mon_en = 1'b1;

        // Default run with exact DONE timing, ACK+BEG together, then an immediate restart.
        tick(); fill_plan(cyc, 1'b0); apply(1'b1, 1'b0);
        c0 = cyc;
        repeat (33) begin tick(); apply(1'b0, 1'b0); end
        chk("done_low_at_c33", int'(DONE), 0);
        tick(); apply(1'b0, 1'b0);
        chk("done_high_at_c34", int'(DONE), 1);
        drive_run(2, 1'b0, 1'b1);
        tick(); fill_plan(cyc, 1'b0); apply(1'b1, 1'b0);
        // BEG held high through a whole run; it restarts only once IDLE is reached.
        drive_run(0, 1'b1, 1'b0);
        tick(); fill_plan(cyc, 1'b0); apply(1'b1, 1'b0);
        drive_run(1, 1'b0, 1'b0);
        repeat (2) begin tick(); apply(1'b0, 1'b0); end

        // Reset while ADRS=10.
        tick(); fill_plan(cyc, 1'b0); apply(1'b1, 1'b0);
        r = rd_t[10 - FIRST];
        while (cyc < r) begin tick(); apply(1'b0, 1'b0); end
        chk("adrs_before_reset", int'(ADRS), 10);
        RST = 1'b1; m_idle = 1'b1;
        tick();
        RST = 1'b0;
        exp_ld.delete(); exp_rd.delete(); exp_it.delete(); exp_done.delete();
        chk_reset_outputs("midrun");
        repeat (3) begin tick(); apply(1'b0, 1'b0); end
        tick(); fill_plan(cyc, 1'b0); apply(1'b1, 1'b0);
        drive_run(0, 1'b0, 1'b0);

`ifdef CORDIC_STALL_EN
        // Three stall cycles at ADRS=5, plus stalls in IDLE, LOAD and DONE that must be ignored.
        tick(); fill_plan(cyc, 1'b0);
        c0 = cyc;
        STALL = 1'b1; plan[c0] = 1'b1;
        plan[c0 + 1] = 1'b1;
        plan[c0 + 6] = 1'b1; plan[c0 + 7] = 1'b1; plan[c0 + 8] = 1'b1;
        plan[c0 + 37] = 1'b1; plan[c0 + 38] = 1'b1;
        apply(1'b1, 1'b0);
        while (cyc < c0 + 8) begin
            tick(); apply(1'b0, 1'b0);
            if (cyc >= c0 + 6) begin
                chk("stall_adrs_hold", int'(ADRS), 5);
                chk("stall_en_rom1", int'(EN_ROM1), 0);
                chk("stall_en_iter", int'(EN_ITER), 0);
            end
        end
        while (cyc < c0 + 36) begin tick(); apply(1'b0, 1'b0); end
        chk("stall_done_low_at_c36", int'(DONE), 0);
        tick(); apply(1'b0, 1'b1);
        chk("stall_done_high_at_c37", int'(DONE), 1);
        tick(); apply(1'b0, 1'b0);
        chk("stall_ack_in_done", int'(READY), 1);
`endif

        // Single-address instance.
        tick(); apply(1'b0, 1'b0); beg1 = 1'b1;
        tick(); apply(1'b0, 1'b0); beg1 = 1'b0;
        chk("n1_ld_init", int'(ld_b), 1);
        chk("n1_ready_low", int'(rdy_b), 0);
        tick(); apply(1'b0, 1'b0);
        chk("n1_en_rom1", int'(en_rom_b), 1);
        chk("n1_adrs", int'(adrs_b), 4);
        chk("n1_no_iter_yet", int'(it_b), 0);
        tick(); apply(1'b0, 1'b0);
        chk("n1_rom_off", int'(en_rom_b), 0);
        chk("n1_en_iter", int'(it_b), 1);
        chk("n1_done_low", int'(done_b), 0);
        tick(); apply(1'b0, 1'b0);
        chk("n1_done", int'(done_b), 1);
        chk("n1_iter_off", int'(it_b), 0);
        chk("n1_adrs_hold", int'(adrs_b), 4);
        ack1 = 1'b1;
        tick(); apply(1'b0, 1'b0); ack1 = 1'b0;
        chk("n1_ready_again", int'(rdy_b), 1);
        chk("n1_done_cleared", int'(done_b), 0);

        // Randomized runs with input noise and (when enabled) random stalls.
        runs = 0; guard = 0;
        while (((runs < 10) || !m_idle) && (guard < 20000)) begin
            bit b, a;
            tick();
            guard++;
            if (m_idle) begin
                b = ($urandom_range(0, 2) == 0);
                if (b) begin fill_plan(cyc, 1'b1); runs++; end
                apply(b, $urandom_range(0, 3) == 0);
            end else if (cyc >= done_t) begin
                a = ($urandom_range(0, 2) == 0);
                apply(a ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0), a);
            end else begin
                apply($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            end
        end
        repeat (3) begin tick(); apply(1'b0, 1'b0); end
        chk("ready_at_end", int'(READY), 1);
        chk("ld_queue_drained", exp_ld.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        chk("it_queue_drained", exp_it.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cordic_iter_ctrl.md
CORDIC_ITER_CTRL -- requirements
Module: cordic_iter_ctrl

Interface
REQ-001 Parameter ADRS_FIRST, default 1, first LUT_SHIFT-style address issued (range 0..31).
REQ-002 Parameter ADRS_LAST, default 31, last address issued; ADRS_FIRST <= ADRS_LAST; N = ADRS_LAST-ADRS_FIRST+1.
REQ-003 CLK  in  1  single clock, rising edge.
REQ-004 RST  in  1  synchronous reset, active-high.
REQ-005 BEG_FSM  in  1  start request, sampled only in IDLE.
REQ-006 ACK_FSM  in  1  acknowledge of DONE, sampled only in DONE.
REQ-007 STALL  in  1  freeze iteration sequencing (present only with CORDIC_STALL_EN).
REQ-008 EN_ROM1  out  1  read enable to the shift-amount ROM.
REQ-009 ADRS  out  5  ROM address, i.e. current iteration index.
REQ-010 LD_INIT  out  1  one-cycle strobe loading initial X/Y/Z into datapath.
REQ-011 EN_ITER  out  1  datapath iteration strobe, aligned with valid ROM output O_D.
REQ-012 READY  out  1  high iff state is IDLE.
REQ-013 DONE  out  1  result valid, held until acknowledged.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, ITER, DRAIN, DONE.
REQ-015 IDLE & BEG_FSM -> LOAD; BEG_FSM in any other state SHALL be ignored.
REQ-016 LOAD SHALL last one cycle with LD_INIT=1, then -> ITER with ADRS=ADRS_FIRST.
REQ-017 ITER: EN_ROM1=1; ADRS increments by 1 per cycle; ADRS=ADRS_LAST cycle -> DRAIN; ADRS never wraps.
REQ-018 ROM latency is 1 cycle: EN_ITER SHALL be high exactly in the cycle after each cycle with EN_ROM1=1 (registered pending flag).
REQ-019 DRAIN: EN_ROM1=0, EN_ITER=1 for the final address, then -> DONE.
REQ-020 DONE: DONE=1 until ACK_FSM sampled high, then -> IDLE; simultaneous BEG_FSM in that cycle SHALL be ignored.
REQ-021 Timing with BEG_FSM sampled at end of cycle c: LD_INIT in c+1, ADRS_FIRST..ADRS_LAST in c+2..c+1+N, EN_ITER in c+3..c+2+N, DONE from c+3+N.
REQ-022 ADRS SHALL hold its last value outside ITER; EN_ROM1, EN_ITER, LD_INIT SHALL be 0 outside their stated states.

Reset
REQ-023 RST SHALL override all other inputs, including mid-run.
REQ-024 After a reset edge: state IDLE, ADRS=0, EN_ROM1=0, EN_ITER=0, LD_INIT=0, DONE=0, pending flag cleared, READY=1.
REQ-025 No strobe from an interrupted run SHALL appear after reset.

Configuration
REQ-026 Macro CORDIC_STALL_EN defined: STALL port exists; while STALL=1 in ITER or DRAIN, state, ADRS and pending flag SHALL hold, and EN_ROM1 and EN_ITER SHALL be forced 0 combinationally; sequencing resumes unchanged when STALL falls.
REQ-027 STALL SHALL have no effect in IDLE, LOAD or DONE.
REQ-028 Macro undefined: STALL port absent; behaviour identical to STALL=0.

Structure
REQ-029 Shared package cordic_ctrl_pkg SHALL hold the FSM state enum, address width constant (5) and default ADRS_FIRST/ADRS_LAST.
REQ-030 Single module; no sub-module; ROM instantiated externally and driven by EN_ROM1/ADRS.

Verification
REQ-031 Defaults, BEG_FSM pulse at c -> LD_INIT at c+1, ADRS 1..31 at c+2..c+32, EN_ITER c+3..c+33, DONE from c+34 until ACK_FSM, then READY=1.
REQ-032 BEG_FSM held high throughout a run -> exactly one run; new run only after return to IDLE.
REQ-033 RST at the cycle ADRS=10 -> next cycle all outputs at reset values, READY=1; following BEG_FSM restarts at ADRS=1.
REQ-034 ADRS_FIRST=ADRS_LAST=4 -> single ADRS=4 cycle at c+2, one EN_ITER at c+3, DONE at c+4.
REQ-035 CORDIC_STALL_EN, STALL high 3 cycles while ADRS=5 -> ADRS holds 5, EN_ROM1/EN_ITER low for 3 cycles, DONE delayed by exactly 3 cycles versus REQ-031.
REQ-036 ACK_FSM and BEG_FSM together in DONE -> IDLE next cycle, no LOAD; BEG_FSM the following cycle starts a run.
